// File: rtl/dispense_monitor.sv
// ============================================================================
//  Module      : dispense_monitor
//  Description : Pill-drop monitor for the dispense path. Synchronizes and
//                debounces the beam-break sensor, counts pills against the
//                expected dose, and reports completion, spurious drops,
//                re-dispense requests and faults.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEBOUNCE_CYCLES : stable synchronized samples needed to change the
//                      filtered sensor level (>= 1)
//    TIMEOUT_CYCLES  : cycles allowed between start / last pill / retry and
//                      the next pill (>= 2)
//    MAX_RETRIES     : re-dispense requests before declaring fault (0..7)
//
//  Ports
//    clock    in   system clock, rising edge
//    reset    in   asynchronous active-high reset
//    start    in   dispense commanded (accepted in IDLE, DONE, FAULT)
//    expected in   [2:0] pills expected, sampled on accepted start
//    sensor   in   raw asynchronous beam-break input, 1 = beam broken
//    busy     out  high while waiting for pills (WAIT, RETRY)
//    retry    out  one-cycle re-dispense request
//    done     out  one-cycle dose-complete pulse
//    fault    out  sticky: dose not completed
//    extra    out  sticky: pill seen while not waiting for one
//    dropped  out  [2:0] pills counted for the current dose (saturating)
//
//  Build option
//    DISPENSE_MONITOR_RETRY_EN : when defined, a timeout issues up to
//                                MAX_RETRIES re-dispense requests before
//                                faulting. When undefined, every timeout
//                                faults immediately and retry stays 0.
// ============================================================================

`default_nettype none

module dispense_monitor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int MAX_RETRIES     = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] expected,
    input  logic       sensor,
    output logic       busy,
    output logic       retry,
    output logic       done,
    output logic       fault,
    output logic       extra,
    output logic [2:0] dropped
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [c_DB_W-1:0]  c_DB_LAST  = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_RETRY = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Sensor path: 2-flop synchronizer, debounce filter, rising-edge detect
    // ------------------------------------------------------------------------
    logic              r_sync1;
    logic              r_sync2;
    logic              r_filt;
    logic              r_filt_d;
    logic [c_DB_W-1:0] r_db_cnt;
    logic              r_pill;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_filt   <= 1'b0;
            r_filt_d <= 1'b0;
            r_db_cnt <= '0;
            r_pill   <= 1'b0;
        end else begin
            r_sync1  <= sensor;
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            // Pill pulse is the registered 0->1 transition of the filtered level.
            r_pill   <= r_filt & ~r_filt_d;

            // Count consecutive disagreeing samples; any agreeing sample
            // restarts the run.
            if (r_sync2 != r_filt) begin
                if (r_db_cnt == c_DB_LAST) begin
                    r_filt   <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Dose-control state machine
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic [2:0]         r_expected;
    logic [2:0]         r_dropped;
    logic [c_TMR_W-1:0] r_timer;
    logic               r_busy;
    logic               r_retry;
    logic               r_done;
    logic               r_fault;
    logic               r_extra;

    logic [2:0]         w_dropped_inc;
    logic               w_retry_ok;

    assign w_dropped_inc = (r_dropped == 3'd7) ? 3'd7 : (r_dropped + 3'd1);

`ifdef DISPENSE_MONITOR_RETRY_EN
    localparam logic [2:0] c_RETRY_LIMIT = 3'(MAX_RETRIES);
    logic [2:0] r_retries;
    assign w_retry_ok = (r_retries < c_RETRY_LIMIT);
`else
    // Without the retry feature every timeout faults; r_retry is never set,
    // so the retry output is constant 0.
    assign w_retry_ok = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_expected <= 3'd0;
            r_dropped  <= 3'd0;
            r_timer    <= '0;
            r_busy     <= 1'b0;
            r_retry    <= 1'b0;
            r_done     <= 1'b0;
            r_fault    <= 1'b0;
            r_extra    <= 1'b0;
`ifdef DISPENSE_MONITOR_RETRY_EN
            r_retries  <= 3'd0;
`endif
        end else begin
            r_retry <= 1'b0;
            r_done  <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE, S_FAULT: begin
                    if (start) begin
                        r_expected <= expected;
                        r_timer    <= '0;
                        r_fault    <= 1'b0;
                        r_extra    <= 1'b0;
`ifdef DISPENSE_MONITOR_RETRY_EN
                        r_retries  <= 3'd0;
`endif
                        if (expected == 3'd0) begin
                            r_dropped <= 3'd0;
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_busy    <= 1'b0;
                        end else if (r_pill) begin
                            // A pill coinciding with start belongs to the new
                            // dose and may complete it outright.
                            r_dropped <= 3'd1;
                            if (expected == 3'd1) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_WAIT;
                                r_busy  <= 1'b1;
                            end
                        end else begin
                            r_dropped <= 3'd0;
                            r_state   <= S_WAIT;
                            r_busy    <= 1'b1;
                        end
                    end else begin
                        if (r_pill) begin
                            r_extra <= 1'b1;
                        end
                        if (r_state == S_DONE) begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                S_WAIT: begin
                    if (r_pill) begin
                        // A pill takes priority over a coincident timeout.
                        r_dropped <= w_dropped_inc;
                        r_timer   <= '0;
                        if (w_dropped_inc == r_expected) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else if (r_timer == c_TMR_LAST) begin
                        if (w_retry_ok) begin
                            r_state   <= S_RETRY;
                            r_retry   <= 1'b1;
                            r_timer   <= '0;
`ifdef DISPENSE_MONITOR_RETRY_EN
                            r_retries <= r_retries + 3'd1;
`endif
                        end else begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_RETRY: begin
                    // Single-cycle state; a pill here is outside WAIT.
                    if (r_pill) begin
                        r_extra <= 1'b1;
                    end
                    r_state <= S_WAIT;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign retry   = r_retry;
    assign done    = r_done;
    assign fault   = r_fault;
    assign extra   = r_extra;
    assign dropped = r_dropped;

endmodule

`default_nettype wire

// File: doc/dispense_monitor.md
# dispense_monitor

Receive-side counterpart of the dispense actuator path. After the dispenser drives its GPIO output, this block watches the pill-drop sensor on a GPIO input, debounces it, and counts pills against the expected dose. It reports completion, flags spurious drops, and requests re-dispense on timeout or raises a fault. It sits between the board's sensor pin and the dose-control logic that issues dispense requests.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required before the filtered sensor level changes (≥1).
- TIMEOUT_CYCLES, 1000: cycles allowed between start (or last pill, or retry) and the next pill (≥2).
- MAX_RETRIES, 2: re-dispense requests issued before declaring fault (0–7).
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: a dispense was commanded; accepted only in IDLE, DONE or FAULT.
- expected  in  3  pills expected for this dose; sampled on accepted start.
- sensor  in  1  raw asynchronous beam-break input, 1 = beam broken.
- busy  out  1  high in WAIT and RETRY.
- retry  out  1  one-cycle pulse requesting the actuator fire again.
- done  out  1  one-cycle pulse: dose complete.
- fault  out  1  sticky: dose not completed; cleared by the next accepted start or reset.
- extra  out  1  sticky: pill detected while not in WAIT; cleared by the next accepted start or reset.
- dropped  out  3  pills counted for the current dose; saturates at 7.

## Operation
- Sensor path:
  - Two-flop synchronizer.
  - Debounce counter: the filtered level toggles once the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing sample resets the counter.
  - A filtered 0→1 edge produces a one-cycle internal pill pulse.
- States: IDLE, WAIT, RETRY, DONE, FAULT. The FSM is coded with one-hot or binary encoding, implementer's choice.
- IDLE / DONE / FAULT, on start:
  - Load expected; clear dropped, retries, timer, fault and extra.
  - If expected ≠ 0, go to WAIT.
  - If expected = 0, go to DONE.
- WAIT:
  - Timer increments every cycle.
  - A pill pulse increments dropped and zeroes the timer.
  - If the incremented dropped equals expected, go to DONE.
  - If timer = TIMEOUT_CYCLES−1 with no pill that cycle: go to RETRY when retry is enabled and retries < MAX_RETRIES, otherwise go to FAULT.
- RETRY: lasts exactly one cycle. Assert retry, retries+1, timer zeroed, then return to WAIT. Pills counted so far are kept.
- DONE: lasts one cycle with done=1, then IDLE, unless start is present that cycle, in which case start is accepted.
- FAULT: holds fault=1 until an accepted start or reset.
- Boundary rules:
  - Pill and timeout in the same cycle: the pill wins and the timer is zeroed.
  - Pill in the same cycle as an accepted start: counted toward the new dose if expected ≠ 0, and does not set extra.
  - start in WAIT/RETRY is ignored.
  - A pill in IDLE/DONE/FAULT sets extra; dropped is unchanged.
  - dropped never wraps past 7.
- Reset (any time, including mid-dose):
  - State goes to IDLE.
  - All outputs, counters, synchronizer and filtered level go to 0.

## Timing
- Raw sensor rise to pill pulse: 2 + DEBOUNCE_CYCLES + 1 cycles when stable.
- Final pill pulse to done: done is high on the next cycle.
- Timeout: retry or fault asserted TIMEOUT_CYCLES cycles after WAIT entry or after the last timer zeroing.
- start to busy: busy rises on the cycle after start is sampled.
- All outputs are registered.

## Configuration
- DISPENSE_MONITOR_RETRY_EN
  - Defined: RETRY state, retries counter and retry output behave as above.
  - Undefined: the retry port still exists but is tied to 0. Every timeout in WAIT goes straight to FAULT, and MAX_RETRIES is ignored.

## Test plan
- expected=2, two clean 10-cycle sensor pulses 50 cycles apart: dropped 1 then 2. done pulses once, 1 cycle after the second pill pulse. fault=0, extra=0.
- 2-cycle glitch on sensor with DEBOUNCE_CYCLES=4: no pill pulse, dropped stays 0. Same for a glitch on the falling side during a held pulse.
- Retry enabled, MAX_RETRIES=2, expected=1, no sensor activity: retry pulses at TIMEOUT_CYCLES and 2×TIMEOUT_CYCLES+1. Fault rises at 3×TIMEOUT_CYCLES+2 and stays high. The same run with the macro undefined: fault at TIMEOUT_CYCLES, retry never asserts.
- Pill pulse landing exactly on timer = TIMEOUT_CYCLES−1: counted, no retry, timer restarts.
- Sensor pulse while IDLE: extra=1, dropped=0. The next start with expected=1 clears extra.
- Reset asserted mid-WAIT with dropped=1: all outputs read 0 asynchronously. After release, state is IDLE and a new start behaves normally.
